// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversampling receive controller for the serial MIDI input.
// It finds start and stop bits on the RX line and sequences an external
// LSB-first serial-in/parallel-out shift register through SR_CE/SR_CLR/SR_D.
// Good frames latch the register contents into DATA and pulse VALID.
// Bad stop bits pulse FRAME_ERR.
module uart_rx_ctrl #(
    parameter int W        = 8,
    parameter int BAUD_DIV = 1600
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         RX,
    output logic         SR_CE,
    output logic         SR_CLR,
    output logic         SR_DIR,
    output logic         SR_D,
    input  logic [W-1:0] SR_Q,
    output logic [W-1:0] DATA,
    output logic         VALID,
    output logic         FRAME_ERR,
    output logic         BUSY
);

    localparam int H  = BAUD_DIV / 2;
    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam int BW = $clog2(W + 1);

    localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HI
    } state_t;

    state_t          state;
    state_t          stateNext;
    logic            rxMeta;
    logic            rxS;
    logic [CW-1:0]   cnt;
    logic [BW-1:0]   bitn;
    logic            cntClr;
    logic            bitnInc;
    logic            srCeNext;
    logic            srClrNext;
    logic            srDNext;
    logic            validNext;
    logic            frameErrNext;
    logic            dataLoad;

    // The register only ever shifts toward the LSB, so direction is fixed.
    assign SR_DIR = 1'b1;
    assign BUSY   = (state != S_IDLE);

    // Two-flop synchronizer; idles high so reset does not look like a start bit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rxMeta <= 1'b1;
            rxS    <= 1'b1;
        end else begin
            rxMeta <= RX;
            rxS    <= rxMeta;
        end
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic; sampling points are half a bit into START and a full bit thereafter.
    always_comb begin
        stateNext    = state;
        cntClr       = 1'b0;
        bitnInc      = 1'b0;
        srCeNext     = 1'b0;
        srClrNext    = 1'b0;
        srDNext      = SR_D;
        validNext    = 1'b0;
        frameErrNext = 1'b0;
        dataLoad     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rxS) begin
                    stateNext = S_START;
                    srClrNext = 1'b1;
                end
            end
            S_START: begin
                if (cnt == CNT_HALF) begin
                    stateNext = rxS ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == CNT_FULL) begin
                    srCeNext = 1'b1;
                    srDNext  = rxS;
                    bitnInc  = 1'b1;
                    cntClr   = 1'b1;
                    if (bitn == BIT_LAST) begin
                        stateNext = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (cnt == CNT_FULL) begin
                    if (rxS) begin
                        dataLoad  = 1'b1;
                        validNext = 1'b1;
                        stateNext = S_IDLE;
                    end else begin
                        frameErrNext = 1'b1;
                        stateNext    = S_WAIT_HI;
                    end
                end
            end
            S_WAIT_HI: begin
                if (rxS) begin
                    stateNext = S_IDLE;
                end
            end
            default: begin
                stateNext = S_IDLE;
            end
        endcase
        if (stateNext != state) begin
            cntClr = 1'b1;
        end
    end

    // Bit-period counter restarts on every state change and after each data bit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (cntClr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Data-bit index only advances while receiving data bits.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bitn <= '0;
        end else if (state != S_DATA) begin
            bitn <= '0;
        end else if (bitnInc) begin
            bitn <= bitn + BW'(1);
        end
    end

    // Registered shift-register controls and status pulses.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            SR_CE     <= 1'b0;
            SR_CLR    <= 1'b0;
            SR_D      <= 1'b0;
            VALID     <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            SR_CE     <= srCeNext;
            SR_CLR    <= srClrNext;
            SR_D      <= srDNext;
            VALID     <= validNext;
            FRAME_ERR <= frameErrNext;
        end
    end

    // Output byte is held until the next frame with a good stop bit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            DATA <= '0;
        end else if (dataLoad) begin
            DATA <= SR_Q;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: drives serial frames into uart_rx_ctrl with an attached
// shift register and compares the observed control/status pulses against
// event timelines computed from the frame timing rules.
module tb_uart_rx_ctrl;

    localparam int W = 8;
    localparam int B = 16;
    localparam int H = B / 2;

    localparam logic [1:0] EV_CLR   = 2'd0;
    localparam logic [1:0] EV_CE    = 2'd1;
    localparam logic [1:0] EV_VALID = 2'd2;
    localparam logic [1:0] EV_ERR   = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] t;
        logic [7:0]  v;
    } ev_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         rx  = 1'b1;
    logic         srCe;
    logic         srClr;
    logic         srDir;
    logic         srD;
    logic [W-1:0] srQ = '0;
    logic [W-1:0] dataOut;
    logic         valid;
    logic         frameErr;
    logic         busy;

    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    int  ruleViolations = 0;
    ev_t recEvents[$];
    ev_t expEvents[$];
    logic [7:0] expData = 8'h00;

    uart_rx_ctrl #(.W(W), .BAUD_DIV(B)) dut (
        .CLK(clk),
        .RST(rst),
        .RX(rx),
        .SR_CE(srCe),
        .SR_CLR(srClr),
        .SR_DIR(srDir),
        .SR_D(srD),
        .SR_Q(srQ),
        .DATA(dataOut),
        .VALID(valid),
        .FRAME_ERR(frameErr),
        .BUSY(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External shift register: clear wins, otherwise shift toward the LSB.
    always @(posedge clk) begin
        if (srClr) srQ <= '0;
        else if (srCe) srQ <= srDir ? {srD, srQ[W-1:1]} : {srQ[W-2:0], srD};
    end

    // Observe every pulse away from the active edge and log it with its cycle.
    always @(negedge clk) begin
        if (srClr)    recEvents.push_back(ev_t'{kind: EV_CLR,   t: 32'(cyc), v: 8'd0});
        if (srCe)     recEvents.push_back(ev_t'{kind: EV_CE,    t: 32'(cyc), v: {7'd0, srD}});
        if (valid)    recEvents.push_back(ev_t'{kind: EV_VALID, t: 32'(cyc), v: dataOut});
        if (frameErr) recEvents.push_back(ev_t'{kind: EV_ERR,   t: 32'(cyc), v: dataOut});
        if ((srCe && srClr) || (valid && frameErr) || (srDir !== 1'b1)) ruleViolations++;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference timeline of one frame whose first low sample edge is e0.
    task automatic modelFrame(input int e0, input logic [7:0] d, input logic stopBit, input int nCe);
        expEvents.push_back(ev_t'{kind: EV_CLR, t: 32'(e0 + 2), v: 8'd0});
        for (int i = 0; i < nCe; i++)
            expEvents.push_back(ev_t'{kind: EV_CE, t: 32'(e0 + 2 + H + (i + 1) * B), v: {7'd0, d[i]}});
        if (nCe == W) begin
            if (stopBit) begin
                expEvents.push_back(ev_t'{kind: EV_VALID, t: 32'(e0 + 2 + H + (W + 1) * B), v: d});
                expData = d;
            end else begin
                expEvents.push_back(ev_t'{kind: EV_ERR, t: 32'(e0 + 2 + H + (W + 1) * B), v: expData});
            end
        end
    endtask

    // Serialise start, W data bits LSB-first and stop; caller sits just after a rising edge.
    task automatic applyStimulus(input logic [7:0] d, input logic stopBit, input int nBits, output int e0);
        logic [W+1:0] bits;
        bits = {stopBit, d, 1'b0};
        e0 = cyc + 1;
        for (int k = 0; k < nBits; k++) begin
            rx = bits[k];
            waitCycles(B);
        end
    endtask

    function automatic int eventDiffs();
        int n;
        n = 0;
        if (recEvents.size() != expEvents.size()) return 1000 + recEvents.size();
        foreach (expEvents[i]) if (recEvents[i] !== expEvents[i]) n++;
        return n;
    endfunction

    function automatic void clearLogs();
        recEvents.delete();
        expEvents.delete();
    endfunction

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({srCe, srClr, srD, valid, frameErr, busy} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags: got %b required 000000", {srCe, srClr, srD, valid, frameErr, busy});
        end
        checks++;
        if (dataOut !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_data: got %h required 00", dataOut);
        end
        checks++;
        if (srDir !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_dir: got %b required 1", srDir);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        clearLogs();
    endtask

    task automatic test_idle();
        int bad;
        bad = 0;
        clearLogs();
        repeat (1000) begin
            @(negedge clk);
            if ({srCe, srClr, valid, frameErr, busy} !== 5'b0 || srDir !== 1'b1) bad++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("[TB] FAIL idle_outputs: got %0d active cycles required 0", bad);
        end
        checks++;
        if (recEvents.size() !== 0) begin
            failures++;
            $display("[TB] FAIL idle_events: got %0d events required 0", recEvents.size());
        end
    endtask

    task automatic test_single_frame();
        int e0;
        clearLogs();
        applyStimulus(8'h90, 1'b1, W + 2, e0);
        modelFrame(e0, 8'h90, 1'b1, W);
        waitCycles(8);
        checks++;
        if (eventDiffs() !== 0) begin
            failures++;
            $display("[TB] FAIL single_events: got %0d differences required 0 (%0d events seen)", eventDiffs(), recEvents.size());
        end
        checks++;
        if (dataOut !== 8'h90) begin
            failures++;
            $display("[TB] FAIL single_data: got %h required 90", dataOut);
        end
    endtask

    task automatic test_back_to_back();
        int e0a, e0b;
        clearLogs();
        applyStimulus(8'h45, 1'b1, W + 2, e0a);
        applyStimulus(8'hA3, 1'b1, W + 2, e0b);
        modelFrame(e0a, 8'h45, 1'b1, W);
        modelFrame(e0b, 8'hA3, 1'b1, W);
        waitCycles(8);
        checks++;
        if (eventDiffs() !== 0) begin
            failures++;
            $display("[TB] FAIL b2b_events: got %0d differences required 0 (%0d events seen)", eventDiffs(), recEvents.size());
        end
        checks++;
        if (dataOut !== 8'hA3) begin
            failures++;
            $display("[TB] FAIL b2b_data: got %h required a3", dataOut);
        end
    endtask

    task automatic test_glitch();
        int e0;
        clearLogs();
        e0 = cyc + 1;
        rx = 1'b0;
        waitCycles(4);
        rx = 1'b1;
        modelFrame(e0, 8'h00, 1'b1, 0);
        waitCycles(30);
        checks++;
        if (eventDiffs() !== 0) begin
            failures++;
            $display("[TB] FAIL glitch_events: got %0d differences required 0 (%0d events seen)", eventDiffs(), recEvents.size());
        end
        checks++;
        if (dataOut !== expData) begin
            failures++;
            $display("[TB] FAIL glitch_data: got %h required %h", dataOut, expData);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL glitch_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_frame_error();
        int e0, e1;
        clearLogs();
        applyStimulus(8'h3C, 1'b0, W + 2, e0);
        modelFrame(e0, 8'h3C, 1'b0, W);
        waitCycles(200);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ferr_busy_low: got %b required 1", busy);
        end
        rx = 1'b1;
        waitCycles(2);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ferr_busy_sync: got %b required 1", busy);
        end
        waitCycles(2);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ferr_busy_release: got %b required 0", busy);
        end
        waitCycles(5);
        applyStimulus(8'h7F, 1'b1, W + 2, e1);
        modelFrame(e1, 8'h7F, 1'b1, W);
        waitCycles(8);
        checks++;
        if (eventDiffs() !== 0) begin
            failures++;
            $display("[TB] FAIL ferr_events: got %0d differences required 0 (%0d events seen)", eventDiffs(), recEvents.size());
        end
        checks++;
        if (dataOut !== 8'h7F) begin
            failures++;
            $display("[TB] FAIL ferr_data: got %h required 7f", dataOut);
        end
    endtask

    task automatic test_reset_midframe();
        int e0, e1;
        clearLogs();
        applyStimulus(8'h5A, 1'b1, 5, e0);
        modelFrame(e0, 8'h5A, 1'b1, 4);
        rst = 1'b1;
        rx  = 1'b1;
        #1;
        expData = 8'h00;
        checks++;
        if ({srCe, srClr, srD, valid, frameErr, busy} !== 6'b0 || srDir !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midreset_flags: got %b dir=%b required 000000 dir=1", {srCe, srClr, srD, valid, frameErr, busy}, srDir);
        end
        checks++;
        if (dataOut !== 8'h00) begin
            failures++;
            $display("[TB] FAIL midreset_data: got %h required 00", dataOut);
        end
        @(posedge clk);
        #1;
        waitCycles(2);
        rst = 1'b0;
        waitCycles(2 * B);
        applyStimulus(8'h12, 1'b1, W + 2, e1);
        modelFrame(e1, 8'h12, 1'b1, W);
        waitCycles(8);
        checks++;
        if (eventDiffs() !== 0) begin
            failures++;
            $display("[TB] FAIL midreset_events: got %0d differences required 0 (%0d events seen)", eventDiffs(), recEvents.size());
        end
        checks++;
        if (dataOut !== 8'h12) begin
            failures++;
            $display("[TB] FAIL midreset_data2: got %h required 12", dataOut);
        end
    endtask

    task automatic test_random_frames();
        int e0;
        logic [7:0] d;
        clearLogs();
        for (int n = 0; n < 6; n++) begin
            waitCycles($urandom_range(0, 20));
            d = 8'($urandom);
            applyStimulus(d, 1'b1, W + 2, e0);
            modelFrame(e0, d, 1'b1, W);
        end
        waitCycles(8);
        checks++;
        if (eventDiffs() !== 0) begin
            failures++;
            $display("[TB] FAIL random_events: got %0d differences required 0 (%0d events seen)", eventDiffs(), recEvents.size());
        end
        checks++;
        if (dataOut !== expData) begin
            failures++;
            $display("[TB] FAIL random_data: got %h required %h", dataOut, expData);
        end
    endtask

    task automatic checkOutput();
        checks++;
        if (ruleViolations !== 0) begin
            failures++;
            $display("[TB] FAIL pulse_rules: got %0d violating cycles required 0", ruleViolations);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single_frame();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_reset_midframe();
        test_random_frames();
        checkOutput();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
